// File: rtl/seq_booth_mult.sv
// Sequential WIDTH x WIDTH multiplier, one partial-product step per clock.
// tc=0 selects unsigned shift-add, tc=1 selects signed radix-2 Booth.
module seq_booth_mult #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 tc,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state;
   logic [WIDTH:0]     acc;      // A, with guard bit
   logic [WIDTH:0]     mcand;    // M, extended per mode
   logic [WIDTH-1:0]   mplier;   // Q
   logic               q_m1;
   logic               mode;
   logic [CNT_W-1:0]   cnt;

   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     acc_nxt;
   logic [WIDTH-1:0]   mplier_nxt;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      sum = acc;
      if (!mode) begin
         if (mplier[0]) sum = acc + mcand;
      end else begin
         case ({mplier[0], q_m1})
            2'b01:   sum = acc + mcand;
            2'b10:   sum = acc - mcand;
            default: sum = acc;
         endcase
      end
      // Signed mode replicates the sign; unsigned shifts in zero.
      acc_nxt    = {mode & sum[WIDTH], sum[WIDTH:1]};
      mplier_nxt = {sum[0], mplier[WIDTH-1:1]};
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         acc     <= '0;
         mcand   <= '0;
         mplier  <= '0;
         q_m1    <= 1'b0;
         mode    <= 1'b0;
         cnt     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         product <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  acc    <= '0;
                  mplier <= a;
                  mcand  <= tc ? {b[WIDTH-1], b} : {1'b0, b};
                  q_m1   <= 1'b0;
                  mode   <= tc;
                  cnt    <= '0;
                  state  <= RUN;
                  busy   <= 1'b1;
                  done   <= 1'b0;
               end
            end
            RUN: begin
               acc    <= acc_nxt;
               mplier <= mplier_nxt;
               q_m1   <= mplier[0];
               cnt    <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(WIDTH - 1)) begin
                  state   <= DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  product <= {acc_nxt[WIDTH-1:0], mplier_nxt};
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_booth_mult.sv
// Directed and model-based checks of seq_booth_mult at WIDTH 8, 4 and 16.
module tb_seq_booth_mult;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic        start8 = 0, tc8 = 0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic        busy8, done8;
   logic [15:0] prod8;

   logic        start4 = 0, tc4 = 0;
   logic [3:0]  a4 = '0, b4 = '0;
   logic        busy4, done4;
   logic [7:0]  prod4;

   logic        start16 = 0, tc16 = 0;
   logic [15:0] a16 = '0, b16 = '0;
   logic        busy16, done16;
   logic [31:0] prod16;

   seq_booth_mult #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .tc(tc8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .product(prod8));

   seq_booth_mult #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .tc(tc4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .product(prod4));

   seq_booth_mult #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start16), .tc(tc16), .a(a16), .b(b16),
      .busy(busy16), .done(done16), .product(prod16));

   // Start one 8-bit operation; return product and edges from accept to done.
   task automatic op8(input logic t, input logic [7:0] x, input logic [7:0] y,
                      output logic [15:0] p, output int lat);
      @(negedge clk); start8 = 1; tc8 = t; a8 = x; b8 = y;
      @(negedge clk); start8 = 0; lat = 0;
      while (!done8 && lat < 40) begin @(negedge clk); lat++; end
      p = prod8;
   endtask

   task automatic chk8(input string name, input logic [15:0] got, input logic [15:0] exp,
                       input int lat);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: product got %h expected %h", name, got, exp);
      end
      checks++;
      if (lat != 8) begin
         errors++;
         $display("FAIL %s latency: got %0d expected 8", name, lat);
      end
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({busy8, done8, prod8} !== 18'd0 || {busy4, done4, prod4} !== 10'd0) begin
         errors++;
         $display("FAIL reset_values: w8 busy %b done %b prod %h, w4 busy %b done %b prod %h expected zeros",
                  busy8, done8, prod8, busy4, done4, prod4);
      end
      #11 rst_n = 1;
      repeat (2) @(negedge clk);
      checks++;
      if (busy8 !== 0 || done8 !== 0) begin
         errors++;
         $display("FAIL idle_after_reset: busy %b done %b expected 0 0", busy8, done8);
      end
   endtask

   task automatic test_unsigned_max();
      int lat;
      int bad;
      bad = 0;
      @(negedge clk); start8 = 1; tc8 = 0; a8 = 8'hFF; b8 = 8'hFF;
      @(negedge clk); start8 = 0; lat = 0;
      while (!done8 && lat < 40) begin
         if (busy8 !== 1 || prod8 !== 16'h0000) bad++;
         @(negedge clk); lat++;
      end
      chk8("unsigned_ff_ff", prod8, 16'hFE01, lat);
      checks++;
      if (bad != 0 || busy8 !== 0) begin
         errors++;
         $display("FAIL busy_window: bad cycles %0d busy at done %b expected 0 0", bad, busy8);
      end
   endtask

   task automatic test_signed();
      logic [15:0] p;
      int lat;
      op8(1, 8'h80, 8'h80, p, lat); chk8("signed_min_sq", p, 16'h4000, lat);
      op8(1, 8'hFD, 8'h05, p, lat); chk8("signed_m3_x5",  p, 16'hFFF1, lat);
      op8(1, 8'h7F, 8'h81, p, lat); chk8("signed_127_m127", p, 16'hC0FF, lat);
      op8(0, 8'h80, 8'h80, p, lat); chk8("unsigned_80_80", p, 16'h4000, lat);
      op8(1, 8'hFF, 8'h7F, p, lat); chk8("signed_m1_x127", p, 16'hFF81, lat);
   endtask

   task automatic test_zero_and_restart();
      logic [15:0] p;
      int lat;
      op8(0, 8'h00, 8'hA5, p, lat); chk8("zero_x_a5", p, 16'h0000, lat);
      repeat (3) @(negedge clk);
      checks++;
      if (done8 !== 1 || prod8 !== 16'h0000) begin
         errors++;
         $display("FAIL done_hold: done %b prod %h expected 1 0000", done8, prod8);
      end
      start8 = 1; tc8 = 0; a8 = 8'h0C; b8 = 8'h0A;
      @(negedge clk); start8 = 0;
      checks++;
      if (done8 !== 0 || busy8 !== 1) begin
         errors++;
         $display("FAIL restart_from_done: done %b busy %b expected 0 1", done8, busy8);
      end
      lat = 0;
      while (!done8 && lat < 40) begin @(negedge clk); lat++; end
      chk8("restart_0c_0a", prod8, 16'h0078, lat);
   endtask

   task automatic test_start_ignored();
      int lat;
      @(negedge clk); start8 = 1; tc8 = 0; a8 = 8'h03; b8 = 8'h04;
      @(negedge clk); start8 = 0; lat = 0;
      repeat (2) begin @(negedge clk); lat++; end
      start8 = 1; a8 = 8'hFF; tc8 = 1;
      @(negedge clk); lat++; start8 = 0;
      while (!done8 && lat < 40) begin @(negedge clk); lat++; end
      chk8("start_in_run_ignored", prod8, 16'h000C, lat);
   endtask

   task automatic test_async_reset();
      logic [15:0] p;
      int lat;
      @(negedge clk); start8 = 1; tc8 = 0; a8 = 8'h09; b8 = 8'h09;
      @(negedge clk); start8 = 0;
      repeat (3) @(negedge clk);
      #2 rst_n = 0;
      #1;
      checks++;
      if (busy8 !== 0 || done8 !== 0 || prod8 !== 16'h0000) begin
         errors++;
         $display("FAIL async_reset: busy %b done %b prod %h expected 0 0 0000", busy8, done8, prod8);
      end
      @(negedge clk); rst_n = 1;
      repeat (12) @(negedge clk);
      checks++;
      if (busy8 !== 0 || done8 !== 0 || prod8 !== 16'h0000) begin
         errors++;
         $display("FAIL idle_after_abort: busy %b done %b prod %h expected 0 0 0000", busy8, done8, prod8);
      end
      op8(0, 8'h06, 8'h07, p, lat); chk8("fresh_6x7", p, 16'h002A, lat);
   endtask

   task automatic test_w4_exhaustive();
      int bad_p, bad_l, lat;
      logic signed [7:0] sx, sy;
      logic [7:0] exp;
      bad_p = 0; bad_l = 0;
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < 256; i++) begin
            @(negedge clk); start4 = 1; tc4 = m[0]; a4 = i[7:4]; b4 = i[3:0];
            @(negedge clk); start4 = 0; lat = 0;
            while (!done4 && lat < 20) begin @(negedge clk); lat++; end
            if (m == 0) exp = {4'd0, i[7:4]} * {4'd0, i[3:0]};
            else begin
               sx = {{4{i[7]}}, i[7:4]}; sy = {{4{i[3]}}, i[3:0]};
               exp = sx * sy;
            end
            if (prod4 !== exp) begin
               bad_p++;
               if (bad_p < 5) $display("FAIL w4 vec tc=%0d a=%h b=%h: got %h expected %h",
                                       m, i[7:4], i[3:0], prod4, exp);
            end
            if (lat != 4) bad_l++;
         end
      end
      checks++;
      if (bad_p != 0) begin
         errors++;
         $display("FAIL w4_exhaustive: %0d wrong products expected 0", bad_p);
      end
      checks++;
      if (bad_l != 0) begin
         errors++;
         $display("FAIL w4_latency: %0d vectors off latency 4 expected 0", bad_l);
      end
   endtask

   task automatic test_w16_random();
      int bad_p, bad_l, lat;
      logic signed [31:0] sx, sy;
      logic [31:0] exp;
      logic [15:0] x, y;
      bad_p = 0; bad_l = 0;
      for (int i = 0; i < 1000; i++) begin
         x = 16'($urandom); y = 16'($urandom);
         if (i == 0) begin x = 16'h8000; y = 16'h8000; end
         if (i == 1) begin x = 16'hFFFF; y = 16'hFFFF; end
         @(negedge clk); start16 = 1; tc16 = i[0]; a16 = x; b16 = y;
         @(negedge clk); start16 = 0; a16 = ~x; lat = 0;
         while (!done16 && lat < 40) begin @(negedge clk); lat++; end
         if (!i[0]) exp = {16'd0, x} * {16'd0, y};
         else begin
            sx = {{16{x[15]}}, x}; sy = {{16{y[15]}}, y};
            exp = sx * sy;
         end
         if (prod16 !== exp) begin
            bad_p++;
            if (bad_p < 5) $display("FAIL w16 vec tc=%0d a=%h b=%h: got %h expected %h",
                                    i[0], x, y, prod16, exp);
         end
         if (lat != 16) bad_l++;
      end
      checks++;
      if (bad_p != 0) begin
         errors++;
         $display("FAIL w16_random: %0d wrong products expected 0", bad_p);
      end
      checks++;
      if (bad_l != 0) begin
         errors++;
         $display("FAIL w16_latency: %0d vectors off latency 16 expected 0", bad_l);
      end
   endtask

   initial begin
      test_reset();
      test_unsigned_max();
      test_signed();
      test_zero_and_restart();
      test_start_ignored();
      test_async_reset();
      test_w4_exhaustive();
      test_w16_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
